sensor_spi_slave: RTL and testbench
===================================

// Module: sensor_spi_slave
// PURPOSE
//  Responder end of the 5-wire GVISION200 sensor register SPI. Emulates the sensor's 256-bit config register.
//  - Write path: master shifts 256 bits in on spi_in, then a spi_write pulse commits them to reg_q.
//  - Read path: while spi_read is high, reg_q is shifted back out on spi_out.
//  Used for FPGA loopback/bring-up of the sensor config path without a sensor fitted.
// PARAMETERS
//  REG_W        256     register width in bits (multiple of 8)
//  SYNC_STAGES  2       synchroniser flops on each SPI input (>=2)
//  RESET_VALUE  256'h0  reg_q value after reset
// PORTS
//  clk_fix       in   1      system clock; fclk >= 8x f(spi_clk)
//  rst_fix       in   1      synchronous reset, active-high
//  spi_clk       in   1      SPI clock from master (async to clk_fix)
//  spi_in        in   1      serial data master->slave
//  spi_write     in   1      commit strobe, level-high
//  spi_read      in   1      read window, level-high
//  spi_out       out  1      serial data slave->master
//  reg_q         out  REG_W  committed register contents
//  reg_update    out  1      1-cycle pulse when reg_q is loaded
//  wr_err        out  1      1-cycle pulse on rejected commit (0 when feature is off)
//  bit_cnt       out  9      bits shifted since last IDLE, saturates at 511
// BEHAVIOUR
//  Interface: one clock, clk_fix; rst_fix is synchronous, active-high.
//  Reset: state=IDLE; spi_out=0; reg_q=RESET_VALUE; reg_update=0; wr_err=0; bit_cnt=0;
//   shift registers cleared. Reset mid-transfer aborts the transfer and leaves no partial commit.
//  Input conditioning: all four SPI inputs pass through SYNC_STAGES flops, followed by rise/fall detect.
//   Edge-to-action latency is SYNC_STAGES+1 clk_fix cycles.
//  State machine, sh_in[REG_W-1:0]:
//   IDLE      : spi_clk rise with spi_read=0 -> SHIFT_IN, captures first bit.
//               spi_read rise -> SHIFT_OUT.
//   SHIFT_IN  : each spi_clk rise: sh_in <= {sh_in[REG_W-2:0], spi_in}; bit_cnt++ (saturating).
//               First bit received ends in sh_in[REG_W-1] (byte 31 bit 7).
//   COMMIT    : entered on spi_write rise from IDLE or SHIFT_IN.
//               Action: reg_q <= sh_in; reg_update=1 for 1 cycle; bit_cnt=0; -> IDLE.
//   SHIFT_OUT : on entry: sh_out <= reg_q; spi_out <= reg_q[REG_W-1].
//               Each spi_clk fall: shift sh_out left, zero-fill; spi_out <= new MSB.
//               After REG_W falls spi_out stays 0.
//               spi_read fall -> spi_out=0, bit_cnt=0, -> IDLE.
//  Boundaries:
//   - spi_write and spi_read rise in the same cycle: write wins; read is ignored until its next rise.
//   - spi_read rise during SHIFT_IN: ignored.
//   - spi_write rise during SHIFT_OUT: ignored.
//   - More than REG_W bits before commit: oldest bits fall off the MSB; only the last REG_W are kept.
//   - spi_clk edges while in COMMIT: dropped (COMMIT lasts 1 cycle).
//   - reg_q is stable except in the COMMIT cycle.
// CONFIGURATION
//  SENSOR_SPI_SLAVE_LEN_CHECK_EN:
//   defined -> COMMIT loads reg_q only if bit_cnt == REG_W exactly; otherwise reg_q is held,
//              wr_err pulses 1 cycle, reg_update stays 0, bit_cnt=0, -> IDLE.
//   undefined -> every commit loads sh_in unconditionally; wr_err is tied 0.
// STRUCTURE
//  sensor_spi_pkg: REG_W default, BITCNT_W=9, one-hot state localparams
//   (S_IDLE, S_SHIFT_IN, S_COMMIT, S_SHIFT_OUT).
//  Sub-module spi_sync_edge (SYNC_STAGES flops + rise/fall pulses), instantiated once per
//   SPI input (x4). Top level holds the FSM, shifters and counter.
// TESTING
//  T1 reset: assert rst_fix 3 cycles -> reg_q=RESET_VALUE, spi_out=0, reg_update=0, bit_cnt=0.
//  T2 write: 256 bits of {32{8'hA5}} at fclk/8, then spi_write 4 spi_clk periods
//     -> reg_q=={32{8'hA5}}, exactly one reg_update pulse.
//  T3 readback after T2: spi_read high + 256 spi_clk -> sampled spi_out stream == A5 repeated, MSB first;
//     spi_out=0 on clocks 257-260.
//  T4 short write, 200 bits of 1s then spi_write:
//     macro on  -> wr_err pulse, reg_q unchanged;
//     macro off -> reg_q[199:0] all 1, reg_update pulse.
//  T5 rst_fix asserted after 100 bits -> bit_cnt=0, reg_q=RESET_VALUE;
//     a following full 256-bit write of 256'h0123..EF commits exactly that value.
//  T6 spi_write and spi_read rise in the same clk_fix cycle -> COMMIT occurs,
//     spi_out stays 0 until spi_read toggles low then high.

Source files
------------

// File: rtl/sensor_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_spi_pkg
//  Purpose  : Shared constants, state encoding and helpers for the
//             GVISION200 config-register SPI responder.
//  Revision : 1.0  initial release
// ============================================================================
package sensor_spi_pkg;

   localparam int REG_W_DEF = 256;
   localparam int BITCNT_W  = 9;

   // One-hot state encoding
   typedef enum logic [3:0] {
      S_IDLE      = 4'b0001,
      S_SHIFT_IN  = 4'b0010,
      S_COMMIT    = 4'b0100,
      S_SHIFT_OUT = 4'b1000
   } state_t;

   // Saturating increment for the bit counter (holds at all-ones)
   function automatic logic [BITCNT_W-1:0] sat_inc(input logic [BITCNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Multi-flop synchroniser for one asynchronous SPI line, with
//             single-cycle rise/fall pulses derived from the synced level.
//  Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Synchroniser chain plus one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/sensor_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_spi_slave
//  Purpose  : Responder for the 5-wire GVISION200 sensor register SPI.
//             Emulates the sensor's REG_W-bit config register: serial
//             write with commit strobe, serial readback under spi_read.
//  Options  : SENSOR_SPI_SLAVE_LEN_CHECK_EN - reject commits whose bit
//             count is not exactly REG_W (pulses wr_err instead).
//  Revision : 1.0  initial release
// ============================================================================
module sensor_spi_slave
   import sensor_spi_pkg::*;
#(
   parameter int               REG_W       = REG_W_DEF,
   parameter int               SYNC_STAGES = 2,
   parameter logic [REG_W-1:0] RESET_VALUE = '0
) (
   input  logic                clk_fix,
   input  logic                rst_fix,
   input  logic                spi_clk,
   input  logic                spi_in,
   input  logic                spi_write,
   input  logic                spi_read,
   output logic                spi_out,
   output logic [REG_W-1:0]    reg_q,
   output logic                reg_update,
   output logic                wr_err,
   output logic [BITCNT_W-1:0] bit_cnt
);

   // Synchronised levels and edge pulses of the four SPI inputs
   logic w_clk_lvl, w_clk_rise, w_clk_fall;
   logic w_din_lvl, w_din_rise, w_din_fall;
   logic w_wr_lvl,  w_wr_rise,  w_wr_fall;
   logic w_rd_lvl,  w_rd_rise,  w_rd_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk(clk_fix), .rst(rst_fix), .i_async(spi_clk),
      .o_level(w_clk_lvl), .o_rise(w_clk_rise), .o_fall(w_clk_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
      .clk(clk_fix), .rst(rst_fix), .i_async(spi_in),
      .o_level(w_din_lvl), .o_rise(w_din_rise), .o_fall(w_din_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
      .clk(clk_fix), .rst(rst_fix), .i_async(spi_write),
      .o_level(w_wr_lvl), .o_rise(w_wr_rise), .o_fall(w_wr_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
      .clk(clk_fix), .rst(rst_fix), .i_async(spi_read),
      .o_level(w_rd_lvl), .o_rise(w_rd_rise), .o_fall(w_rd_fall));

   // Edge/level outputs the protocol has no use for
   logic w_unused_sync;
   assign w_unused_sync = &{w_clk_lvl, w_din_rise, w_din_fall,
                            w_wr_lvl, w_wr_fall};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [REG_W-1:0]    r_sh_in;
   logic [REG_W-1:0]    r_sh_out;
   logic [REG_W-1:0]    r_reg_q;
   logic                r_spi_out;
   logic                r_reg_update;
   logic [BITCNT_W-1:0] r_bit_cnt;

   // State register
   always_ff @(posedge clk_fix) begin
      if (rst_fix) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state decode; a write rise always beats a simultaneous read rise
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_wr_rise)                    w_state_nxt = S_COMMIT;
            else if (w_rd_rise)               w_state_nxt = S_SHIFT_OUT;
            else if (w_clk_rise && !w_rd_lvl) w_state_nxt = S_SHIFT_IN;
         end
         S_SHIFT_IN: begin
            if (w_wr_rise) w_state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            w_state_nxt = S_IDLE;
         end
         S_SHIFT_OUT: begin
            if (w_rd_fall) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef SENSOR_SPI_SLAVE_LEN_CHECK_EN
   localparam logic [BITCNT_W-1:0] c_FULL_CNT = BITCNT_W'(REG_W);
   logic r_wr_err;
`endif

   // Shifters, committed register, bit counter and output pulses
   always_ff @(posedge clk_fix) begin
      if (rst_fix) begin
         r_sh_in      <= '0;
         r_sh_out     <= '0;
         r_reg_q      <= RESET_VALUE;
         r_spi_out    <= 1'b0;
         r_reg_update <= 1'b0;
         r_bit_cnt    <= '0;
`ifdef SENSOR_SPI_SLAVE_LEN_CHECK_EN
         r_wr_err     <= 1'b0;
`endif
      end else begin
         r_reg_update <= 1'b0;
`ifdef SENSOR_SPI_SLAVE_LEN_CHECK_EN
         r_wr_err     <= 1'b0;
`endif
         unique case (r_state)
            S_IDLE: begin
               if (w_state_nxt == S_SHIFT_IN) begin
                  r_sh_in   <= {r_sh_in[REG_W-2:0], w_din_lvl};
                  r_bit_cnt <= sat_inc(r_bit_cnt);
               end else if (w_state_nxt == S_SHIFT_OUT) begin
                  r_sh_out  <= r_reg_q;
                  r_spi_out <= r_reg_q[REG_W-1];
               end
            end
            S_SHIFT_IN: begin
               // Clock edges coinciding with the commit rise are dropped
               if (w_state_nxt == S_SHIFT_IN && w_clk_rise) begin
                  r_sh_in   <= {r_sh_in[REG_W-2:0], w_din_lvl};
                  r_bit_cnt <= sat_inc(r_bit_cnt);
               end
            end
            S_COMMIT: begin
`ifdef SENSOR_SPI_SLAVE_LEN_CHECK_EN
               if (r_bit_cnt == c_FULL_CNT) begin
                  r_reg_q      <= r_sh_in;
                  r_reg_update <= 1'b1;
               end else begin
                  r_wr_err     <= 1'b1;
               end
`else
               r_reg_q      <= r_sh_in;
               r_reg_update <= 1'b1;
`endif
               r_bit_cnt <= '0;
            end
            S_SHIFT_OUT: begin
               if (w_rd_fall) begin
                  r_spi_out <= 1'b0;
                  r_bit_cnt <= '0;
               end else if (w_clk_fall) begin
                  // Zero-fill so the line idles low once all bits are out
                  r_sh_out  <= {r_sh_out[REG_W-2:0], 1'b0};
                  r_spi_out <= r_sh_out[REG_W-2];
                  r_bit_cnt <= sat_inc(r_bit_cnt);
               end
            end
            default: begin
               r_spi_out <= 1'b0;
            end
         endcase
      end
   end

   assign spi_out    = r_spi_out;
   assign reg_q      = r_reg_q;
   assign reg_update = r_reg_update;
   assign bit_cnt    = r_bit_cnt;
`ifdef SENSOR_SPI_SLAVE_LEN_CHECK_EN
   assign wr_err     = r_wr_err;
`else
   assign wr_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sensor_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sensor_spi_slave
//  Purpose  : Directed self-checking bench for sensor_spi_slave: reset,
//             full write/commit, readback, short write, mid-transfer
//             reset and simultaneous write/read strobes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sensor_spi_slave;

   localparam int REG_W = 256;

   logic             clk_fix = 1'b0;
   logic             rst_fix;
   logic             spi_clk;
   logic             spi_in;
   logic             spi_write;
   logic             spi_read;
   logic             spi_out;
   logic [REG_W-1:0] reg_q;
   logic             reg_update;
   logic             wr_err;
   logic [8:0]       bit_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_fix = ~clk_fix;

   sensor_spi_slave dut (
      .clk_fix    (clk_fix),
      .rst_fix    (rst_fix),
      .spi_clk    (spi_clk),
      .spi_in     (spi_in),
      .spi_write  (spi_write),
      .spi_read   (spi_read),
      .spi_out    (spi_out),
      .reg_q      (reg_q),
      .reg_update (reg_update),
      .wr_err     (wr_err),
      .bit_cnt    (bit_cnt)
   );

   task automatic check(input string tag, input logic [REG_W-1:0] obs,
                        input logic [REG_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_fix);
   endtask

   // One master write bit at fclk/8: data set with clk low, rise, fall
   task automatic wr_bit(input logic b);
      spi_in = b;
      idle(4);
      spi_clk = 1'b1;
      idle(4);
      spi_clk = 1'b0;
   endtask

   // One master read bit: sample just before the rising edge
   task automatic rd_bit(output logic b);
      idle(4);
      b = spi_out;
      spi_clk = 1'b1;
      idle(4);
      spi_clk = 1'b0;
   endtask

   // Hold spi_write for 4 spi_clk periods, counting output pulses
   task automatic commit(output int n_upd, output int n_err);
      n_upd = 0;
      n_err = 0;
      spi_write = 1'b1;
      for (int i = 0; i < 48; i++) begin
         if (i == 32) spi_write = 1'b0;
         @(negedge clk_fix);
         if (reg_update === 1'b1) n_upd++;
         if (wr_err === 1'b1) n_err++;
      end
   endtask

   logic [REG_W-1:0] pat_a5;
   logic [REG_W-1:0] pat_k;
   logic [REG_W-1:0] cap;
   logic [7:0]       byte_v;
   logic             b;
   logic             seen_hi;
   int               upd, err;

   initial begin
      pat_a5    = {32{8'hA5}};
      pat_k     = {4{64'h0123456789ABCDEF}};
      rst_fix   = 1'b1;
      spi_clk   = 1'b0;
      spi_in    = 1'b0;
      spi_write = 1'b0;
      spi_read  = 1'b0;

      // T1 reset
      idle(3);
      check("t1_reg_q", reg_q, '0);
      check("t1_spi_out", {255'd0, spi_out}, '0);
      check("t1_reg_update", {255'd0, reg_update}, '0);
      check("t1_bit_cnt", {247'd0, bit_cnt}, '0);
      rst_fix = 1'b0;
      idle(5);
      check("t1_wr_err", {255'd0, wr_err}, '0);

      // T2 full write of A5 pattern, MSB first
      for (int i = REG_W - 1; i >= 0; i--) wr_bit(pat_a5[i]);
      idle(4);
      check("t2_bit_cnt_pre", {247'd0, bit_cnt}, 256'd256);
      commit(upd, err);
      check("t2_reg_q", reg_q, pat_a5);
      check("t2_upd_pulses", 256'(upd), 256'd1);
      check("t2_err_pulses", 256'(err), 256'd0);
      check("t2_bit_cnt_post", {247'd0, bit_cnt}, '0);

      // T3 readback
      spi_read = 1'b1;
      idle(8);
      for (int i = REG_W - 1; i >= 0; i--) begin
         rd_bit(b);
         cap[i] = b;
      end
      check("t3_stream", cap, pat_a5);
      for (int i = 0; i < 4; i++) begin
         rd_bit(b);
         check("t3_tail_zero", {255'd0, b}, '0);
      end
      spi_read = 1'b0;
      idle(8);
      check("t3_out_after", {255'd0, spi_out}, '0);
      check("t3_bit_cnt_after", {247'd0, bit_cnt}, '0);

      // T4 short write: 200 ones
      for (int i = 0; i < 200; i++) wr_bit(1'b1);
      idle(4);
      check("t4_bit_cnt_pre", {247'd0, bit_cnt}, 256'd200);
      commit(upd, err);
`ifdef SENSOR_SPI_SLAVE_LEN_CHECK_EN
      check("t4_reg_q_held", reg_q, pat_a5);
      check("t4_err_pulses", 256'(err), 256'd1);
      check("t4_upd_pulses", 256'(upd), 256'd0);
`else
      check("t4_reg_q", reg_q, {{7{8'hA5}}, {200{1'b1}}});
      check("t4_upd_pulses", 256'(upd), 256'd1);
      check("t4_err_pulses", 256'(err), 256'd0);
`endif
      check("t4_bit_cnt_post", {247'd0, bit_cnt}, '0);

      // T5 reset after 100 bits, then a full write of pat_k
      for (int i = 0; i < 100; i++) wr_bit(i[0]);
      idle(4);
      check("t5_bit_cnt_mid", {247'd0, bit_cnt}, 256'd100);
      rst_fix = 1'b1;
      idle(3);
      rst_fix = 1'b0;
      idle(2);
      check("t5_bit_cnt_rst", {247'd0, bit_cnt}, '0);
      check("t5_reg_q_rst", reg_q, '0);
      for (int i = REG_W - 1; i >= 0; i--) wr_bit(pat_k[i]);
      idle(4);
      commit(upd, err);
      check("t5_reg_q", reg_q, pat_k);
      check("t5_upd_pulses", 256'(upd), 256'd1);

      // T6 write and read rise together: commit wins, read ignored
      spi_write = 1'b1;
      spi_read  = 1'b1;
      upd = 0;
      err = 0;
      seen_hi = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_fix);
         if (reg_update === 1'b1) upd++;
         if (wr_err === 1'b1) err++;
         if (spi_out !== 1'b0) seen_hi = 1'b1;
      end
`ifdef SENSOR_SPI_SLAVE_LEN_CHECK_EN
      check("t6_err_pulses", 256'(err), 256'd1);
      check("t6_upd_pulses", 256'(upd), 256'd0);
`else
      check("t6_upd_pulses", 256'(upd), 256'd1);
      check("t6_err_pulses", 256'(err), 256'd0);
`endif
      check("t6_reg_q", reg_q, pat_k);
      for (int i = 7; i >= 0; i--) begin
         rd_bit(b);
         byte_v[i] = b;
         if (spi_out !== 1'b0) seen_hi = 1'b1;
      end
      check("t6_ignored_read", {248'd0, byte_v}, '0);
      check("t6_out_quiet", {255'd0, seen_hi}, '0);
      spi_write = 1'b0;
      spi_read  = 1'b0;
      idle(10);
      spi_read = 1'b1;
      idle(8);
      for (int i = 7; i >= 0; i--) begin
         rd_bit(b);
         byte_v[i] = b;
      end
      check("t6_new_read", {248'd0, byte_v}, 256'h01);
      spi_read = 1'b0;
      idle(8);
      check("t6_out_idle", {255'd0, spi_out}, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
